// File: rtl/rng_pkg.sv
// Shared types and constants for the random-byte transmit FIFO.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

  localparam logic [15:0] DROP_SAT = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == DROP_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO; pointers wrap modulo DEPTH, level tracks occupancy.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rng_tx_fifo.sv
// Buffers random bytes and feeds them to a UART through a start/busy handshake.
module rng_tx_fifo
  import rng_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_byte,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_byte,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  localparam int             CW      = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [CW-1:0]  TO_LAST = CW'(BUSY_TIMEOUT - 1);

  tx_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pop, push, drop, full, empty;
  logic [7:0]    head;

  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_byte),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = WAIT_BUSY;
          cnt_nxt   = '0;
        end
      end
      WAIT_BUSY: begin
        // A UART that never raises busy still gets its byte counted as sent.
        if (tx_busy)              state_nxt = WAIT_DONE;
        else if (cnt == TO_LAST)  state_nxt = IDLE;
        else                      cnt_nxt   = cnt + 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_start   <= 1'b0;
      tx_byte    <= 8'h00;
      overflow   <= 1'b0;
      drop_count <= 16'h0000;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tx_start <= pop;
      if (pop) tx_byte <= head;
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
    end
  end

endmodule

// File: tb/tb_rng_tx_fifo.sv
// Randomized and directed checks of rng_tx_fifo against a queue-based reference model.
module tb_rng_tx_fifo;

  localparam int DEPTH = 16;
  localparam int TO    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          rst, in_valid, tx_busy;
  logic [7:0]    in_byte;
  logic          tx_start, overflow;
  logic [7:0]    tx_byte;
  logic [LW-1:0] level;
  logic [15:0]   drop_count;

  int n_chk = 0, n_err = 0;
  int cyc = 0, last_start = -1, prev_start = -1;

  // reference model state
  logic [7:0] q[$];
  bit         m_start, m_ovf, m_active, m_seen_busy;
  int         m_age, m_drops;
  logic [7:0] m_byte;

  rng_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(TO)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock edge of the intended behaviour, using the inputs seen before the edge.
  task automatic model_edge(input bit r, input bit v, input logic [7:0] b, input bit busy);
    bit pop;
    m_start = 0;
    if (r) begin
      q.delete();
      m_ovf = 0; m_drops = 0; m_active = 0; m_seen_busy = 0; m_age = 0; m_byte = 8'h00;
      return;
    end
    pop = !m_active && q.size() > 0 && !busy;
    if (m_active) begin
      if (m_seen_busy) begin
        if (!busy) m_active = 0;
      end else if (busy) begin
        m_seen_busy = 1;
      end else begin
        m_age++;
        if (m_age >= TO) m_active = 0;
      end
    end
    if (pop) begin
      m_byte = q.pop_front();
      m_start = 1; m_active = 1; m_seen_busy = 0; m_age = 0;
    end
    if (v) begin
      if (q.size() < DEPTH) q.push_back(b);
      else begin
        m_ovf = 1;
        if (m_drops < 16'hFFFF) m_drops++;
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit busy, input bit r);
    rst = r; in_valid = v; in_byte = b; tx_busy = busy;
    @(posedge CLK);
    model_edge(r, v, b, busy);
    cyc++;
    #1;
    if (tx_start) begin prev_start = last_start; last_start = cyc; end
    chk("tx_start", tx_start, m_start);
    chk("tx_byte", tx_byte, m_byte);
    chk("level", level, q.size());
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drops);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_byte = 0; tx_busy = 0;
    step(0, 0, 0, 1);
    step(1, 8'h5A, 0, 1);  // reset wins over in_valid
    chk("rst_level", level, 0);
    chk("rst_tx_byte", tx_byte, 0);

    // single byte goes straight out
    step(1, 8'hA5, 0, 0);
    step(0, 0, 0, 0);
    chk("a5_start", tx_start, 1);
    chk("a5_byte", tx_byte, 8'hA5);
    chk("a5_level", level, 0);

    // fill past full while UART busy
    for (int i = 0; i <= DEPTH; i++) step(1, 8'(i), 1, 0);
    chk("full_level", level, DEPTH);
    chk("full_ovf", overflow, 1);
    chk("full_drops", drop_count, 1);

    // push in the same cycle as the start while full
    step(0, 0, 0, 0);
    step(1, 8'h77, 0, 0);
    chk("pushpop_start", tx_start, 1);
    chk("pushpop_level", level, DEPTH);
    chk("pushpop_drops", drop_count, 1);

    // drain with a loosely random UART, then quiet
    for (int i = 0; i < 150; i++) step(0, 0, ($urandom % 3) == 0, 0);
    for (int i = 0; i < 100; i++) step(0, 0, 0, 0);
    chk("drained", level, 0);

    // busy never shows: starts spaced by timeout + IDLE cycle
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
    chk("timeout_gap", last_start - prev_start, TO + 1);

    // reset in WAIT_DONE with 5 left
    for (int i = 0; i < 6; i++) step(1, 8'(8'hC0 + i), 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("pre_rst_level", level, 5);
    step(1, 8'hEE, 1, 1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_drops", drop_count, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    chk("post_rst_start", tx_start, 0);

    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      step(($urandom % 2) == 0, 8'($urandom), ($urandom % 4) == 0, $urandom_range(0, 399) == 0);

    // saturating drop counter
    step(0, 0, 0, 1);
    for (int i = 0; i < 70000 + DEPTH; i++) step(1, 8'(i), 1, 0);
    chk("sat_drops", drop_count, 16'hFFFF);
    for (int i = 0; i < 20; i++) step(1, 8'h33, 1, 0);
    chk("sat_hold", drop_count, 16'hFFFF);
    chk("sat_ovf", overflow, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rng_tx_fifo.md
RNG_TX_FIFO -- requirements
Module: rng_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..256).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 4, cycles to wait for UART busy after a start pulse.
REQ-003 SHALL have port CLK  input  1  the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  one-cycle strobe; in_byte is valid this cycle (from randomized_lfsr word_ready).
REQ-006 SHALL have port in_byte  input  8  random byte to enqueue.
REQ-007 SHALL have port tx_busy  input  1  UART is_transmitting.
REQ-008 SHALL have port tx_start  output  1  one-cycle transmit request to the UART.
REQ-009 SHALL have port tx_byte  output  8  byte for the UART; held stable from the tx_start cycle until the transfer completes.
REQ-010 SHALL have port level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky; set on the first dropped byte.
REQ-012 SHALL have port drop_count  output  16  number of dropped bytes, saturating.

Function
REQ-013 SHALL enqueue in_byte on every in_valid cycle unless the FIFO is full and no pop occurs in the same cycle.
REQ-014 SHALL accept push and pop together when full: level stays DEPTH and the new byte is stored.
REQ-015 SHALL leave level unchanged on push and pop together when empty-plus-one or otherwise non-full.
REQ-016 SHALL treat in_valid while full without a pop as a drop: data is discarded, overflow is set, and drop_count increments, saturating at 0xFFFF.
REQ-017 SHALL wrap read and write pointers modulo DEPTH; level SHALL equal write count minus read count.
REQ-018 SHALL implement the transmit FSM with states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-019 SHALL, in IDLE with level>0 and tx_busy=0, assert tx_start for one cycle, load tx_byte from the head, pop the head in the same cycle, and go to WAIT_BUSY.
REQ-020 SHALL, in WAIT_BUSY, go to WAIT_DONE when tx_busy=1.
REQ-021 SHALL, in WAIT_BUSY, return to IDLE after BUSY_TIMEOUT cycles without tx_busy; the byte is considered sent.
REQ-022 SHALL, in WAIT_DONE, go to IDLE when tx_busy=0.
REQ-023 SHALL NOT issue a new tx_start earlier than the first IDLE cycle after a transfer, so the minimum spacing between starts is 3 cycles.
REQ-024 SHALL keep tx_start low whenever the FIFO is empty or tx_busy=1 in IDLE.
REQ-025 SHALL latch tx_byte only on tx_start; it is otherwise unchanged.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, set the FSM to IDLE, set pointers and level to 0, and drive tx_start=0, tx_byte=0x00, overflow=0 and drop_count=0.
REQ-027 SHALL let rst override in_valid in the same cycle; that byte is not stored.
REQ-028 SHALL, on rst mid-transfer, abandon the transfer and issue no tx_start until rst=0 and the FIFO is refilled.

Structure
REQ-029 SHALL place the FSM state encoding (IDLE=0, WAIT_BUSY=1, WAIT_DONE=2) and the drop_count saturation value in the shared package rng_pkg.
REQ-030 SHALL implement storage and pointers in one sub-module, sync_fifo (push, pop, din, dout, level, full, empty); the FSM, drop logic and counters SHALL live in rng_tx_fifo.
REQ-031 SHALL register all outputs.

Verification
REQ-032 Directed: after reset, in_valid with 0xA5 and tx_busy=0 -> tx_start one cycle later, tx_byte=0xA5, level back to 0.
REQ-033 Directed: hold tx_busy=1, push 17 bytes 0x00..0x10 with DEPTH=16 -> level=16, overflow=1, drop_count=1, and bytes 0x00..0x0F are later transmitted in order.
REQ-034 Directed: when full, in_valid in the same cycle as tx_start -> level stays 16 and drop_count is unchanged.
REQ-035 Directed: tx_busy never asserts after tx_start -> FSM returns to IDLE after 4 cycles and the next byte starts.
REQ-036 Directed: rst asserted while in WAIT_DONE with level=5 -> next cycle level=0, tx_start=0, overflow=0 and drop_count=0.
REQ-037 Directed: force 70000 drops -> drop_count=0xFFFF and it holds at that value.
